// File: rtl/regfile_pkg.sv
// Shared helpers for the register file: address width and packed-port slice offsets.
package regfile_pkg;

    localparam int ZERO_ADDR = 0;

    function automatic int calc_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_lsb(input int k, input int aw);
        return k * aw;
    endfunction

    function automatic int data_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register, set by issue claims,
// cleared by writebacks that carry wclr.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUMREGS  = 32,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = calc_aw(NUMREGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_WR-1:0]    we_i,
    input  logic [NUM_WR*AW-1:0] waddr_i,
    input  logic [NUM_WR-1:0]    wclr_i,
    input  logic                 claim_i,
    input  logic [AW-1:0]        claim_addr_i,
    output logic                 claim_ready_o,
    output logic [NUMREGS-1:0]   busy_o,
    output logic [NUMREGS-1:0]   clr_hit_o
);

    logic [NUMREGS-1:0] busy_q;
    logic [NUMREGS-1:0] busy_d;
    logic [NUMREGS-1:0] clr_vec;
    logic [NUMREGS-1:0] set_vec;
    logic               claim_zero;
    logic               claim_ok;

    always_comb begin
        clr_vec = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (we_i[p] && wclr_i[p]) begin
                clr_vec[waddr_i[addr_lsb(p, AW) +: AW]] = 1'b1;
            end
        end
    end

    // A claim to the hardwired zero register is always accepted but never tracked.
    always_comb begin
        claim_zero = (ZERO_REG != 0) && (claim_addr_i == AW'(ZERO_ADDR));
        claim_ok   = claim_zero | ~busy_q[claim_addr_i] | clr_vec[claim_addr_i];
        set_vec    = '0;
        if (claim_i && claim_ok && !claim_zero) begin
            set_vec[claim_addr_i] = 1'b1;
        end
        // Set is ORed after the clear so a same-cycle handoff keeps the bit.
        busy_d = set_vec | (busy_q & ~clr_vec);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign claim_ready_o = rst_i | claim_ok;
    assign busy_o        = busy_q;
    assign clr_hit_o     = clr_vec;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write priority, optional write-to-read bypass,
// optional hardwired zero register and an attached busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = calc_aw(NUMREGS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_RD-1:0]           re_i,
    input  logic [NUM_RD*AW-1:0]        raddr_i,
    output logic [NUM_RD*DATAWIDTH-1:0] rdata_o,
    output logic [NUM_RD-1:0]           rbusy_o,
    input  logic [NUM_WR-1:0]           we_i,
    input  logic [NUM_WR*AW-1:0]        waddr_i,
    input  logic [NUM_WR*DATAWIDTH-1:0] wdata_i,
    input  logic [NUM_WR-1:0]           wclr_i,
    input  logic                        claim_i,
    input  logic [AW-1:0]               claim_addr_i,
    output logic                        claim_ready_o,
    output logic [NUMREGS-1:0]          busy_o
);

    logic [DATAWIDTH-1:0] bank_q [NUMREGS];
    logic [NUMREGS-1:0]   clr_hit;

    regfile_scoreboard #(
        .NUMREGS  (NUMREGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .we_i          (we_i),
        .waddr_i       (waddr_i),
        .wclr_i        (wclr_i),
        .claim_i       (claim_i),
        .claim_addr_i  (claim_addr_i),
        .claim_ready_o (claim_ready_o),
        .busy_o        (busy_o),
        .clr_hit_o     (clr_hit)
    );

    // Ports are applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUMREGS; r++) begin
                bank_q[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we_i[p] && !((ZERO_REG != 0) &&
                                 (waddr_i[addr_lsb(p, AW) +: AW] == AW'(ZERO_ADDR)))) begin
                    bank_q[waddr_i[addr_lsb(p, AW) +: AW]] <= wdata_i[data_lsb(p, DATAWIDTH) +: DATAWIDTH];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]        ra;
        logic [DATAWIDTH-1:0] rd;
        rdata_o = '0;
        rbusy_o = '0;
        ra      = '0;
        rd      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = raddr_i[addr_lsb(k, AW) +: AW];
            rd = bank_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (we_i[p] && (waddr_i[addr_lsb(p, AW) +: AW] == ra)) begin
                        rd = wdata_i[data_lsb(p, DATAWIDTH) +: DATAWIDTH];
                    end
                end
            end
            if (!rst_i && re_i[k] && !((ZERO_REG != 0) && (ra == AW'(ZERO_ADDR)))) begin
                rdata_o[data_lsb(k, DATAWIDTH) +: DATAWIDTH] = rd;
                // A consumer reading in the writeback cycle gets forwarded data, so it is not busy.
                rbusy_o[k] = busy_o[ra] & ~((BYPASS != 0) & clr_hit[ra]);
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassing instance and a non-bypassing
// instance share one set of stimulus.
module tb_regfile_sb;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int NRD  = 3;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NRD-1:0]    re_i;
    logic [NRD*AW-1:0] raddr_i;
    logic [NRD*DW-1:0] rdata_o, rdata_nb;
    logic [NRD-1:0]    rbusy_o, rbusy_nb;
    logic [NWR-1:0]    we_i, wclr_i;
    logic [NWR*AW-1:0] waddr_i;
    logic [NWR*DW-1:0] wdata_i;
    logic              claim_i;
    logic [AW-1:0]     claim_addr_i;
    logic              claim_ready_o, claim_ready_nb;
    logic [NREG-1:0]   busy_o, busy_nb;

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [2:0]    re;
        int            a0, a1, a2;
        logic [DW-1:0] d0, d1, d2;
        logic [2:0]    rb;
    } vec_t;
    vec_t tbl[4];
    logic [DW-1:0] model [NREG];

    regfile_sb #(.NUMREGS(NREG), .DATAWIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR),
                 .ZERO_REG(1), .BYPASS(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .re_i(re_i), .raddr_i(raddr_i),
        .rdata_o(rdata_o), .rbusy_o(rbusy_o), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .wclr_i(wclr_i), .claim_i(claim_i),
        .claim_addr_i(claim_addr_i), .claim_ready_o(claim_ready_o), .busy_o(busy_o)
    );

    regfile_sb #(.NUMREGS(NREG), .DATAWIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR),
                 .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .re_i(re_i), .raddr_i(raddr_i),
        .rdata_o(rdata_nb), .rbusy_o(rbusy_nb), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .wclr_i(wclr_i), .claim_i(claim_i),
        .claim_addr_i(claim_addr_i), .claim_ready_o(claim_ready_nb), .busy_o(busy_nb)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic pop_cmp(input string nm, input logic [DW-1:0] act);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: got %h, expected queue empty", nm, act);
        end else begin
            check(nm, act, exp_q.pop_front());
        end
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rdata_o[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rd_nb(input int k);
        return rdata_nb[k*DW +: DW];
    endfunction

    task automatic idle();
        re_i = '0; raddr_i = '0; we_i = '0; waddr_i = '0; wdata_i = '0;
        wclr_i = '0; claim_i = 1'b0; claim_addr_i = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        re_i[k] = 1'b1;
        raddr_i[k*AW +: AW] = a[AW-1:0];
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d, input logic clr);
        we_i[p] = 1'b1;
        waddr_i[p*AW +: AW] = a[AW-1:0];
        wdata_i[p*DW +: DW] = d;
        wclr_i[p] = clr;
    endtask

    task automatic claim(input int a);
        claim_i = 1'b1;
        claim_addr_i = a[AW-1:0];
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("rst_busy", busy_o, '0);
        check("rst_claim_ready", claim_ready_o, 1);

        // Reset: write+claim r5, then assert reset mid-cycle with more work in flight
        set_wr(0, 5, 32'hDEADBEEF, 1'b0); claim(5); #2; tick();
        set_rd(0, 5); #2;
        exp_q.push_back(32'hDEADBEEF);
        pop_cmp("r5_before_rst", rd(0));
        check("r5_busy_set", busy_o[5], 1);
        check("r5_rbusy", rbusy_o[0], 1);
        set_rd(1, 6); set_wr(1, 6, 32'h66, 1'b0); claim(6);
        rst_i = 1'b1; #1;
        check("in_rst_rdata0", rd(0), 0);
        check("in_rst_rdata1", rd(1), 0);
        check("in_rst_rbusy", rbusy_o, 0);
        check("in_rst_busy", busy_o, 0);
        check("in_rst_claim_ready", claim_ready_o, 1);
        tick();
        rst_i = 1'b0;
        set_rd(0, 5); set_rd(1, 6); #2;
        check("post_rst_r5", rd(0), 0);
        check("post_rst_r6", rd(1), 0);
        check("post_rst_busy", busy_o, 0);
        tick();

        // Write priority and bypass vs no bypass
        set_wr(0, 3, 32'h11, 1'b0); set_wr(1, 3, 32'h22, 1'b0); set_rd(0, 3); #2;
        check("bypass_prio", rd(0), 32'h22);
        check("nobypass_old", rd_nb(0), 0);
        tick();
        set_rd(0, 3); #2;
        check("bank_prio", rd(0), 32'h22);
        check("nobypass_new", rd_nb(0), 32'h22);
        tick();

        // Hardwired zero register
        set_wr(0, 0, 32'hFFFF_FFFF, 1'b0); claim(0); set_rd(0, 0); #2;
        check("r0_bypass", rd(0), 0);
        check("r0_rbusy", rbusy_o[0], 0);
        check("r0_claim_ready", claim_ready_o, 1);
        tick();
        set_rd(0, 0); #2;
        check("r0_busy", busy_o[0], 0);
        check("r0_read", rd(0), 0);
        tick();

        // Claim, busy read, then writeback with clear in the read cycle
        claim(7); #2;
        check("r7_claim_ready", claim_ready_o, 1);
        tick();
        set_rd(0, 7); #2;
        check("r7_busy", busy_o[7], 1);
        check("r7_rbusy", rbusy_o[0], 1);
        tick();
        set_rd(0, 7); set_wr(0, 7, 32'h55, 1'b1); #2;
        check("r7_wb_rbusy", rbusy_o[0], 0);
        check("r7_wb_rdata", rd(0), 32'h55);
        check("r7_wb_rbusy_nb", rbusy_nb[0], 1);
        check("r7_wb_rdata_nb", rd_nb(0), 0);
        tick();
        check("r7_cleared", busy_o[7], 0);
        check("r7_cleared_nb", busy_nb[7], 0);

        // WAW stall and set-wins handoff
        claim(9); #2; tick();
        claim(9); #2;
        check("r9_stall", claim_ready_o, 0);
        tick();
        check("r9_still_busy", busy_o[9], 1);
        claim(9); set_wr(1, 9, 32'h99, 1'b1); #2;
        check("r9_handoff_ready", claim_ready_o, 1);
        tick();
        check("r9_set_wins", busy_o[9], 1);
        set_wr(0, 9, 32'h9A, 1'b1); #2; tick();
        check("r9_cleared", busy_o[9], 0);

        // Preload for multi-read; clearing a non-busy r12 is a no-op
        set_wr(0, 1, 32'hA1, 1'b0); set_wr(1, 2, 32'hB2, 1'b0); claim(2); #2; tick();
        set_wr(0, 12, 32'hC, 1'b1); #2; tick();
        check("busy_only_r2", busy_o, 32'h0000_0004);
        wclr_i[0] = 1'b1; waddr_i[0 +: AW] = 5'd2; claim_addr_i = 5'd2; #2;
        check("wclr_needs_we", claim_ready_o, 0);
        tick();
        check("r2_still_busy", busy_o[2], 1);

        tbl[0] = '{re: 3'b111, a0: 1, a1: 2, a2: 1, d0: 32'hA1, d1: 32'hB2, d2: 32'hA1, rb: 3'b010};
        tbl[1] = '{re: 3'b101, a0: 1, a1: 2, a2: 1, d0: 32'hA1, d1: 32'h0,  d2: 32'hA1, rb: 3'b000};
        tbl[2] = '{re: 3'b111, a0: 0, a1: 5, a2: 2, d0: 32'h0,  d1: 32'h0,  d2: 32'hB2, rb: 3'b100};
        tbl[3] = '{re: 3'b111, a0: 3, a1: 7, a2: 9, d0: 32'h22, d1: 32'h55, d2: 32'h9A, rb: 3'b000};
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].re[0]) set_rd(0, tbl[i].a0);
            if (tbl[i].re[1]) set_rd(1, tbl[i].a1);
            if (tbl[i].re[2]) set_rd(2, tbl[i].a2);
            exp_q.push_back(tbl[i].d0);
            exp_q.push_back(tbl[i].d1);
            exp_q.push_back(tbl[i].d2);
            #2;
            pop_cmp($sformatf("vec%0d_p0", i), rd(0));
            pop_cmp($sformatf("vec%0d_p1", i), rd(1));
            pop_cmp($sformatf("vec%0d_p2", i), rd(2));
            check($sformatf("vec%0d_rbusy", i), rbusy_o, tbl[i].rb);
            tick();
        end

        // Write without clear keeps busy
        set_wr(0, 2, 32'hB3, 1'b0); #2; tick();
        set_rd(0, 2); #2;
        check("r2_noclr_busy", busy_o[2], 1);
        check("r2_noclr_data", rd(0), 32'hB3);
        tick();

        // Random write/read-back on the upper half of the file
        for (int r = 0; r < NREG; r++) model[r] = '0;
        for (int i = 0; i < 8; i++) begin
            int a;
            logic [DW-1:0] d;
            a = $urandom_range(16, 31);
            d = $urandom;
            set_wr(i % 2, a, d, 1'b0);
            model[a] = d;
            tick();
            set_rd(2, a); #2;
            exp_q.push_back(model[a]);
            pop_cmp($sformatf("rand%0d", i), rd(2));
            check($sformatf("rand%0d_nb", i), rd_nb(2), model[a]);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
